// File: rtl/csc_pair_feeder_if.sv
// Stream bundle for csc_pair_feeder: job control, dense-vector input,
// CSC nonzero input and the two-lane beat output.
interface csc_pair_feeder_if #(
  parameter int IDX_W = 12,
  parameter int COL_W = 12
);
  logic             start;
  logic             done;

  logic             vec_valid;
  logic [31:0]      vec_data;
  logic             vec_empty;
  logic             vec_ready;

  logic             nz_valid;
  logic [31:0]      nz_val;
  logic [IDX_W-1:0] nz_row;
  logic             nz_last;
  logic             nz_ready;

  logic             out_valid;
  logic             out_ready;
  logic [31:0]      val1;
  logic [31:0]      val2;
  logic [IDX_W-1:0] rowIdx1;
  logic [IDX_W-1:0] rowIdx2;
  logic             tag1;
  logic             tag2;
  logic [31:0]      vec;
  logic [COL_W-1:0] col_idx;

  // master drives the streams and consumes beats; slave is the feeder itself
  modport master (
    output start, vec_valid, vec_data, vec_empty, nz_valid, nz_val, nz_row, nz_last, out_ready,
    input  done, vec_ready, nz_ready, out_valid, val1, val2, rowIdx1, rowIdx2, tag1, tag2, vec, col_idx
  );

  modport slave (
    input  start, vec_valid, vec_data, vec_empty, nz_valid, nz_val, nz_row, nz_last, out_ready,
    output done, vec_ready, nz_ready, out_valid, val1, val2, rowIdx1, rowIdx2, tag1, tag2, vec, col_idx
  );
endinterface

// File: rtl/csc_pair_feeder.sv
// Packs CSC nonzeros of each column into two-lane beats with the column's x[col] broadcast.
// Optional macro ZERO_SKIP_EN drops +0/-0 entries instead of packing them.
module csc_pair_feeder #(
  parameter int NUM_COLS = 64,
  parameter int COL_W    = 12,
  parameter int IDX_W    = 12
) (
  input  logic            clk,
  input  logic            reset,
  csc_pair_feeder_if.slave bus
);

  typedef enum logic [2:0] {IDLE, GET_VEC, GET_A, GET_B, EMIT, DONE} state_t;

  localparam logic [COL_W-1:0] LAST_COL = COL_W'(NUM_COLS - 1);

  state_t           state_reg;
  logic             vec_ready_reg;
  logic             nz_ready_reg;
  logic             out_valid_reg;
  logic             done_reg;
  logic             col_end_reg;
  logic [31:0]      val1_reg;
  logic [31:0]      val2_reg;
  logic [31:0]      vec_reg;
  logic [IDX_W-1:0] row1_reg;
  logic [IDX_W-1:0] row2_reg;
  logic             tag1_reg;
  logic             tag2_reg;
  logic [COL_W-1:0] col_idx_reg;

  logic vec_fire;
  logic nz_fire;
  logic out_fire;
  logic last_col;
  logic nz_zero;

  assign vec_fire = bus.vec_valid && vec_ready_reg;
  assign nz_fire  = bus.nz_valid && nz_ready_reg;
  assign out_fire = out_valid_reg && bus.out_ready;
  assign last_col = (col_idx_reg == LAST_COL);

`ifdef ZERO_SKIP_EN
  assign nz_zero = (bus.nz_val[30:0] == 31'd0);
`else
  assign nz_zero = 1'b0;
`endif

  // Ready/valid/done flags are set on the transition into the state that owns them,
  // so they always mirror state_reg without any output decode.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg     <= IDLE;
      vec_ready_reg <= 1'b0;
      nz_ready_reg  <= 1'b0;
      out_valid_reg <= 1'b0;
      done_reg      <= 1'b0;
      col_end_reg   <= 1'b0;
      val1_reg      <= '0;
      val2_reg      <= '0;
      vec_reg       <= '0;
      row1_reg      <= '0;
      row2_reg      <= '0;
      tag1_reg      <= 1'b0;
      tag2_reg      <= 1'b1;
      col_idx_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (bus.start) begin
            col_idx_reg   <= '0;
            vec_ready_reg <= 1'b1;
            state_reg     <= GET_VEC;
          end
        end

        GET_VEC: begin
          if (vec_fire) begin
            vec_reg <= bus.vec_data;
            if (!bus.vec_empty) begin
              vec_ready_reg <= 1'b0;
              nz_ready_reg  <= 1'b1;
              state_reg     <= GET_A;
            end else if (last_col) begin
              vec_ready_reg <= 1'b0;
              done_reg      <= 1'b1;
              state_reg     <= DONE;
            end else begin
              col_idx_reg <= col_idx_reg + COL_W'(1);
            end
          end
        end

        GET_A: begin
          if (nz_fire) begin
            if (nz_zero) begin
              // a skipped zero closing the column produces no beat at all
              if (bus.nz_last) begin
                nz_ready_reg <= 1'b0;
                if (last_col) begin
                  done_reg  <= 1'b1;
                  state_reg <= DONE;
                end else begin
                  col_idx_reg   <= col_idx_reg + COL_W'(1);
                  vec_ready_reg <= 1'b1;
                  state_reg     <= GET_VEC;
                end
              end
            end else begin
              val1_reg <= bus.nz_val;
              row1_reg <= bus.nz_row;
              tag1_reg <= bus.nz_row[0];
              if (bus.nz_last) begin
                val2_reg      <= '0;
                row2_reg      <= '0;
                tag2_reg      <= ~bus.nz_row[0];
                col_end_reg   <= 1'b1;
                nz_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
                state_reg     <= EMIT;
              end else begin
                state_reg <= GET_B;
              end
            end
          end
        end

        GET_B: begin
          if (nz_fire) begin
            if (nz_zero) begin
              if (bus.nz_last) begin
                val2_reg      <= '0;
                row2_reg      <= '0;
                tag2_reg      <= ~tag1_reg;
                col_end_reg   <= 1'b1;
                nz_ready_reg  <= 1'b0;
                out_valid_reg <= 1'b1;
                state_reg     <= EMIT;
              end
            end else begin
              val2_reg      <= bus.nz_val;
              row2_reg      <= bus.nz_row;
              tag2_reg      <= bus.nz_row[0];
              col_end_reg   <= bus.nz_last;
              nz_ready_reg  <= 1'b0;
              out_valid_reg <= 1'b1;
              state_reg     <= EMIT;
            end
          end
        end

        EMIT: begin
          if (out_fire) begin
            out_valid_reg <= 1'b0;
            if (!col_end_reg) begin
              nz_ready_reg <= 1'b1;
              state_reg    <= GET_A;
            end else if (last_col) begin
              done_reg  <= 1'b1;
              state_reg <= DONE;
            end else begin
              col_idx_reg   <= col_idx_reg + COL_W'(1);
              vec_ready_reg <= 1'b1;
              state_reg     <= GET_VEC;
            end
          end
        end

        DONE: begin
          done_reg  <= 1'b0;
          state_reg <= IDLE;
        end

        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

  assign bus.vec_ready = vec_ready_reg;
  assign bus.nz_ready  = nz_ready_reg;
  assign bus.out_valid = out_valid_reg;
  assign bus.done      = done_reg;
  assign bus.val1      = val1_reg;
  assign bus.val2      = val2_reg;
  assign bus.rowIdx1   = row1_reg;
  assign bus.rowIdx2   = row2_reg;
  assign bus.tag1      = tag1_reg;
  assign bus.tag2      = tag2_reg;
  assign bus.vec       = vec_reg;
  assign bus.col_idx   = col_idx_reg;

endmodule

// File: tb/tb_csc_pair_feeder.sv
// Scoreboard bench for csc_pair_feeder: a 3-column instance driven through directed jobs
// plus a 1-column instance checked cycle by cycle.
module tb_csc_pair_feeder;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  csc_pair_feeder_if #(.IDX_W(12), .COL_W(12)) b ();
  csc_pair_feeder_if #(.IDX_W(12), .COL_W(12)) b1 ();

  csc_pair_feeder #(.NUM_COLS(3), .COL_W(12), .IDX_W(12)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (b)
  );

  csc_pair_feeder #(.NUM_COLS(1), .COL_W(12), .IDX_W(12)) dut1 (
    .clk   (clk),
    .reset (reset),
    .bus   (b1)
  );

  typedef struct packed {
    logic [31:0] v1;
    logic [11:0] r1;
    logic        t1;
    logic [31:0] v2;
    logic [11:0] r2;
    logic        t2;
    logic [31:0] vec;
    logic [11:0] col;
  } beat_t;

  beat_t exp_q[$];
  beat_t mon_got;
  beat_t mon_exp;
  int    tests_run    = 0;
  int    tests_failed = 0;
  int    done_cnt     = 0;
  int    beats_seen   = 0;
  logic  done_prev    = 1'b0;

  function automatic beat_t mk(input logic [31:0] v1, input logic [11:0] r1, input logic t1,
                               input logic [31:0] v2, input logic [11:0] r2, input logic t2,
                               input logic [31:0] vec, input logic [11:0] col);
    beat_t x;
    x.v1 = v1; x.r1 = r1; x.t1 = t1;
    x.v2 = v2; x.r2 = r2; x.t2 = t2;
    x.vec = vec; x.col = col;
    return x;
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_beat(input string name, input beat_t got, input beat_t exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got v1=%h r1=%0d t1=%0b v2=%h r2=%0d t2=%0b vec=%h col=%0d expected v1=%h r1=%0d t1=%0b v2=%h r2=%0d t2=%0b vec=%h col=%0d",
               name, got.v1, got.r1, got.t1, got.v2, got.r2, got.t2, got.vec, got.col,
               exp.v1, exp.r1, exp.t1, exp.v2, exp.r2, exp.t2, exp.vec, exp.col);
    end
  endtask

  function automatic beat_t cur_beat();
    return mk(b.val1, b.rowIdx1, b.tag1, b.val2, b.rowIdx2, b.tag2, b.vec, b.col_idx);
  endfunction

  // Monitor: pops one expected beat per accepted output and tracks done pulses.
  initial begin
    forever begin
      @(negedge clk);
      if (b.out_valid && b.out_ready) begin
        mon_got = cur_beat();
        beats_seen++;
        $display("[TB] beat col=%0d v1=%h r1=%0d t1=%0b v2=%h r2=%0d t2=%0b vec=%h",
                 mon_got.col, mon_got.v1, mon_got.r1, mon_got.t1, mon_got.v2, mon_got.r2, mon_got.t2, mon_got.vec);
        if (exp_q.size() == 0) begin
          tests_run++;
          tests_failed++;
          $display("FAIL beat_unexpected: got v1=%h r1=%0d col=%0d required no beat", mon_got.v1, mon_got.r1, mon_got.col);
        end else begin
          mon_exp = exp_q.pop_front();
          chk_beat("beat", mon_got, mon_exp);
        end
      end
      if (b.done) begin
        done_cnt++;
        $display("[TB] done pulse %0d", done_cnt);
        chk("done_one_cycle", {63'd0, done_prev}, 64'd0);
      end
      done_prev = b.done;
    end
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish required finish");
    $fatal(1, "timeout");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send_vec(input logic [31:0] d, input logic e);
    logic acc;
    int   n;
    b.vec_valid = 1'b1;
    b.vec_data  = d;
    b.vec_empty = e;
    n = 0;
    do begin
      acc = b.vec_ready;
      step();
      n++;
    end while (!acc && n < 100);
    b.vec_valid = 1'b0;
    chk("vec_handshake", {63'd0, acc}, 64'd1);
  endtask

  task automatic send_nz(input logic [31:0] v, input logic [11:0] r, input logic last);
    logic acc;
    int   n;
    b.nz_valid = 1'b1;
    b.nz_val   = v;
    b.nz_row   = r;
    b.nz_last  = last;
    n = 0;
    do begin
      acc = b.nz_ready;
      step();
      n++;
    end while (!acc && n < 100);
    b.nz_valid = 1'b0;
    chk("nz_handshake", {63'd0, acc}, 64'd1);
  endtask

  task automatic wait_done(input int n);
    int k;
    k = 0;
    while (done_cnt < n && k < 200) begin
      step();
      k++;
    end
    chk("done_count", 64'(done_cnt), 64'(n));
  endtask

  task automatic start_job();
    b.start = 1'b1;
    step();
    b.start = 1'b0;
  endtask

  initial begin
    b.start = 0; b.vec_valid = 0; b.vec_data = 0; b.vec_empty = 0;
    b.nz_valid = 0; b.nz_val = 0; b.nz_row = 0; b.nz_last = 0; b.out_ready = 1;
    b1.start = 0; b1.vec_valid = 0; b1.vec_data = 0; b1.vec_empty = 0;
    b1.nz_valid = 0; b1.nz_val = 0; b1.nz_row = 0; b1.nz_last = 0; b1.out_ready = 1;

    repeat (3) step();
    chk_beat("reset_fields", cur_beat(), mk(32'h0, 12'd0, 1'b0, 32'h0, 12'd0, 1'b1, 32'h0, 12'd0));
    chk("reset_flags", {60'd0, b.out_valid, b.vec_ready, b.nz_ready, b.done}, 64'd0);
    reset = 1'b1;
    step();
    chk("idle_vec_ready", {63'd0, b.vec_ready}, 64'd0);

    // Job 1: full pair, empty middle column, odd last column
    start_job();
    send_vec(32'h4000_0000, 1'b0);
    exp_q.push_back(mk(32'h3F80_0000, 12'd5, 1'b1, 32'h4040_0000, 12'd6, 1'b0, 32'h4000_0000, 12'd0));
    send_nz(32'h3F80_0000, 12'd5, 1'b0);
    send_nz(32'h4040_0000, 12'd6, 1'b1);
    b.nz_valid = 1'b1; b.nz_val = 32'h4120_0000; b.nz_row = 12'd9; b.nz_last = 1'b1;
    send_vec(32'h4100_0000, 1'b1);
    b.nz_valid = 1'b1;
    chk("empty_col_nz_ready", {63'd0, b.nz_ready}, 64'd0);
    chk("empty_col_advance", 64'(b.col_idx), 64'd2);
    b.nz_valid = 1'b0;
    send_vec(32'h4080_0000, 1'b0);
    exp_q.push_back(mk(32'h3F00_0000, 12'd2, 1'b0, 32'h3E80_0000, 12'd3, 1'b1, 32'h4080_0000, 12'd2));
    exp_q.push_back(mk(32'h3E00_0000, 12'd4, 1'b0, 32'h0, 12'd0, 1'b1, 32'h4080_0000, 12'd2));
    send_nz(32'h3F00_0000, 12'd2, 1'b0);
    send_nz(32'h3E80_0000, 12'd3, 1'b0);
    send_nz(32'h3E00_0000, 12'd4, 1'b1);
    wait_done(1);
    step();

    // Job 2: vec offered in IDLE, backpressure on an odd column, start ignored mid-job
    b.vec_valid = 1'b1; b.vec_data = 32'h3F80_0000; b.vec_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("idle_no_vec_accept", {63'd0, b.vec_ready}, 64'd0);
      step();
    end
    b.vec_valid = 1'b0;
    start_job();
    send_vec(32'h3F80_0000, 1'b0);
    exp_q.push_back(mk(32'h40A0_0000, 12'd2, 1'b0, 32'h40C0_0000, 12'd3, 1'b1, 32'h3F80_0000, 12'd0));
    exp_q.push_back(mk(32'h40E0_0000, 12'd4, 1'b0, 32'h0, 12'd0, 1'b1, 32'h3F80_0000, 12'd0));
    b.out_ready = 1'b0;
    send_nz(32'h40A0_0000, 12'd2, 1'b0);
    send_nz(32'h40C0_0000, 12'd3, 1'b0);
    b.nz_valid = 1'b1; b.nz_val = 32'h40E0_0000; b.nz_row = 12'd4; b.nz_last = 1'b1;
    b.start = 1'b1;
    for (int i = 0; i < 5; i++) begin
      chk("hold_out_valid", {63'd0, b.out_valid}, 64'd1);
      chk("hold_nz_ready", {63'd0, b.nz_ready}, 64'd0);
      chk_beat("hold_fields", cur_beat(),
               mk(32'h40A0_0000, 12'd2, 1'b0, 32'h40C0_0000, 12'd3, 1'b1, 32'h3F80_0000, 12'd0));
      step();
      b.start = 1'b0;
    end
    chk("hold_no_accept", 64'(beats_seen), 64'd3);
    b.out_ready = 1'b1;
    send_nz(32'h40E0_0000, 12'd4, 1'b1);
    send_vec(32'h0, 1'b1);
    send_vec(32'h0, 1'b1);
    wait_done(2);
    chk("col_idx_max", 64'(b.col_idx), 64'd2);
    chk("beats_after_job2", 64'(beats_seen), 64'd5);
    step();

    // Job 3: reset while a beat is held, then a fresh job
    start_job();
    send_vec(32'h4120_0000, 1'b0);
    b.out_ready = 1'b0;
    send_nz(32'h3F80_0000, 12'd8, 1'b0);
    send_nz(32'h3F80_0000, 12'd9, 1'b1);
    chk("pre_abort_valid", {63'd0, b.out_valid}, 64'd1);
    #2 reset = 1'b0;
    #1;
    chk("abort_flags", {61'd0, b.out_valid, b.vec_ready, b.tag2}, 64'd1);
    step();
    chk("abort_flags_next", {61'd0, b.out_valid, b.vec_ready, b.tag2}, 64'd1);
    chk("abort_col_idx", 64'(b.col_idx), 64'd0);
    reset = 1'b1;
    repeat (3) step();
    chk("abort_no_done", 64'(done_cnt), 64'd2);
    b.out_ready = 1'b1;
    start_job();
    chk("restart_vec_ready", {63'd0, b.vec_ready}, 64'd1);
    send_vec(32'h0, 1'b1);
    send_vec(32'h0, 1'b1);
    send_vec(32'h0, 1'b1);
    wait_done(3);
    step();

    // Job 4: column of signed zeros, then an empty and a single-entry column
    start_job();
    send_vec(32'h4000_0000, 1'b0);
`ifndef ZERO_SKIP_EN
    exp_q.push_back(mk(32'h0, 12'd1, 1'b1, 32'h8000_0000, 12'd2, 1'b0, 32'h4000_0000, 12'd0));
`endif
    send_nz(32'h0000_0000, 12'd1, 1'b0);
    send_nz(32'h8000_0000, 12'd2, 1'b1);
    send_vec(32'h3F80_0000, 1'b1);
    send_vec(32'h4040_0000, 1'b0);
    exp_q.push_back(mk(32'h3F80_0000, 12'd7, 1'b1, 32'h0, 12'd0, 1'b0, 32'h4040_0000, 12'd2));
    send_nz(32'h3F80_0000, 12'd7, 1'b1);
    wait_done(4);
    for (int k = 0; k < 50 && exp_q.size() != 0; k++) step();
    chk("scoreboard_empty", 64'(exp_q.size()), 64'd0);

    // Single-column instance: cycle-exact latency and done timing
    b1.start = 1'b1;
    step();
    b1.start = 1'b0;
    chk("n1_vec_ready", {63'd0, b1.vec_ready}, 64'd1);
    b1.vec_valid = 1'b1; b1.vec_data = 32'h4000_0000; b1.vec_empty = 1'b0;
    step();
    b1.vec_valid = 1'b0;
    b1.nz_valid = 1'b1; b1.nz_val = 32'h3F80_0000; b1.nz_row = 12'd5; b1.nz_last = 1'b0;
    chk("n1_nz_ready", {62'd0, b1.nz_ready, b1.out_valid}, 64'd2);
    step();
    b1.nz_val = 32'h4040_0000; b1.nz_row = 12'd6; b1.nz_last = 1'b1;
    chk("n1_no_early_valid", {63'd0, b1.out_valid}, 64'd0);
    step();
    b1.nz_valid = 1'b0;
    chk("n1_out_valid", {63'd0, b1.out_valid}, 64'd1);
    $display("[TB] n1 beat v1=%h r1=%0d v2=%h r2=%0d", b1.val1, b1.rowIdx1, b1.val2, b1.rowIdx2);
    chk_beat("n1_beat", mk(b1.val1, b1.rowIdx1, b1.tag1, b1.val2, b1.rowIdx2, b1.tag2, b1.vec, b1.col_idx),
             mk(32'h3F80_0000, 12'd5, 1'b1, 32'h4040_0000, 12'd6, 1'b0, 32'h4000_0000, 12'd0));
    step();
    chk("n1_done_high", {62'd0, b1.done, b1.out_valid}, 64'd2);
    step();
    chk("n1_done_low", {62'd0, b1.done, b1.vec_ready}, 64'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
